instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer for the 4-bit processor core. Holds a small program store of {opcode, operand} words, fetches them in order and drives the core's `instr` and `portin` inputs. It holds each instruction's operand while the core's memory or ALU operation completes and stops on a HALT word. It sits between the test/host loader and the core, so the core never sees a partially formed instruction stream.

## Interface
- `DEPTH`, 16: program store entries; power of two; PC width = log2(DEPTH).
- `ALU_WAIT`, 2: idle cycles after issuing an ALU opcode (0000–0011).
- `MEM_WAIT`, 2: idle cycles after issuing 0100/0101 (memory read/write).
- `XFER_WAIT`, 1: idle cycles after issuing 1000 (Y→Y1 transfer).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_en` in 1: write `load_data` into store at `load_addr`; honoured only when not busy.
- `load_addr` in log2(DEPTH): store write address.
- `load_data` in 8: {opcode[7:4], operand[3:0]}.
- `start` in 1: one-cycle pulse; begins execution at PC 0; honoured only when not busy.
- `abort` in 1: stops execution.
- `instr` out 4: opcode to core.
- `portin` out 4: operand to core.
- `pc` out log2(DEPTH): address of current instruction.
- `busy` out 1: high in FETCH/ISSUE/WAIT.
- `done` out 1: high after HALT until next `start` or `rst`.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, DONE.
- NOP code is 4'b1001. Outside ISSUE, `instr` = 4'b1001.
- Program word with opcode 1001 is HALT. It is never issued to the core.
- Opcodes 1010–1111 are issued as-is, with 0 wait cycles. The core ignores them.
- IDLE: on `start`, set pc←0, clear `done`, go to FETCH.
- FETCH: latch store[pc] into opcode/operand registers.
  - If the opcode is HALT, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE, lasting exactly 1 cycle:
  - Drive `instr`=opcode and `portin`=operand.
  - Load the wait counter from the opcode class: ALU_WAIT, MEM_WAIT or XFER_WAIT. Opcodes 0110/0111 and 1010–1111 use 0.
  - If the count is 0: pc←pc+1 and go to FETCH.
  - Otherwise go to WAIT.
- WAIT:
  - `portin` holds the operand, because the memory address must stay stable.
  - The counter decrements each cycle.
  - When it reaches 1: pc←pc+1 and go to FETCH.
- DONE: `done`=1; `pc` holds the HALT address. `start` → restart as from IDLE. `load_en` is accepted.
- PC arithmetic is modulo DEPTH. After the last entry, a non-HALT instruction wraps pc to 0 and execution continues.
- `abort` in any busy state:
  - Next state is IDLE; `instr`=1001 from the next cycle.
  - pc holds its value; `done` stays 0.
  - `abort` has priority over state transitions.
- `start` and `load_en` while busy: ignored, no side effects.
- Same cycle `start` and `load_en` in IDLE/DONE: the load is written first, and FETCH reads the new value.
- `rst` wins over everything, including mid-WAIT. The core's in-flight operation is not undone.

## Timing
- Reset values:
  - state IDLE, `pc`=0, `instr`=4'b1001, `portin`=0, `busy`=0, `done`=0.
  - Every store entry = 8'h90 (HALT).
- `start` sampled at edge N: FETCH in cycle N+1, ISSUE (first opcode visible) in cycle N+2.
- Cycles per instruction = 2 + wait count (FETCH + ISSUE + WAIT).
- HALT: FETCH in cycle k, `done`=1 and `busy`=0 from cycle k+1.
- `busy` is registered, asserted from cycle N+1 after `start`.
- Load write takes effect at the edge it is sampled. A FETCH in the following cycle reads the new data.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `start` with an empty store:
  - Fetch of 8'h90 at pc 0 gives `done`=1 two cycles after `start`.
  - `instr` never leaves 1001.
- Load {0110,5},{0111,0},{1001,0}, then `start`:
  - `instr`=0110/`portin`=5 in cycle N+2.
  - `instr`=0111 in cycle N+4.
  - `done` in cycle N+6.
- Load {0100,3},{0000,0},HALT:
  - `portin`=3 held for 3 cycles (ISSUE + 2 WAIT).
  - Next ISSUE occurs 4 cycles after the first.
  - `instr` is 1001 during the waits.
- Fill all 16 entries with {0110,k}, no HALT:
  - pc wraps 15→0 and execution continues.
  - Assert `abort` mid-WAIT: IDLE next cycle, `busy`=0, pc held.
- Pulse `load_en` and `start` while busy: store contents and pc sequence unchanged.
- `rst` asserted during WAIT: all outputs return to their reset values on the next cycle, and the store becomes all 8'h90.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer for the 4-bit core.
// Holds a small store of {opcode, operand} words and fetches them in order.
// It drives instr/portin and keeps the operand stable while the core's
// ALU, memory or transfer operation completes. Execution stops on a HALT word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | not running; store writable, waiting for start
// S_FETCH | read store[pc] into the opcode/operand registers
// S_ISSUE | opcode on instr for exactly one cycle, wait counter loaded
// S_WAIT  | instr back to NOP, portin held until the core settles
// S_DONE  | HALT reached; done high, pc on the HALT word, store writable
module instr_sequencer #(
    parameter int DEPTH     = 16,
    parameter int ALU_WAIT  = 2,
    parameter int MEM_WAIT  = 2,
    parameter int XFER_WAIT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [7:0]               load_data,
    input  logic                     start,
    input  logic                     abort,
    output logic [3:0]               instr,
    output logic [3:0]               portin,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done
);

    localparam int         PW     = $clog2(DEPTH);
    localparam int         CNT_W  = 8;
    localparam logic [3:0] OP_NOP = 4'b1001;   // doubles as the HALT opcode in the store

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [7:0]       store [DEPTH];
    logic [3:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       fetch_word;
    logic [CNT_W-1:0] issue_wait;
    logic             running;

    // Wait cycles owed after an opcode. Opcodes the core ignores, and
    // 0110/0111, need no settling time.
    function automatic logic [CNT_W-1:0] wait_for(input logic [3:0] op);
        logic [CNT_W-1:0] w;
        w = '0;
        if (op[3:2] == 2'b00)
            w = CNT_W'(ALU_WAIT);
        else if (op == 4'b0100 || op == 4'b0101)
            w = CNT_W'(MEM_WAIT);
        else if (op == 4'b1000)
            w = CNT_W'(XFER_WAIT);
        return w;
    endfunction

    // Store read port and the wait count for the opcode being issued.
    always_comb begin
        fetch_word = store[pc];
        issue_wait = wait_for(op_reg);
        running    = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    end

    // Sequencer FSM, store and all registered outputs.
    // Abort is checked ahead of the state case so that it overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            instr  <= OP_NOP;
            portin <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_reg <= OP_NOP;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++)
                store[i] <= 8'h90;
        end else if (abort && running) begin
            state <= S_IDLE;
            instr <= OP_NOP;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // A load and a start in the same cycle let the FETCH see the new word.
                    if (load_en)
                        store[load_addr] <= load_data;
                    if (start) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    op_reg <= fetch_word[7:4];
                    if (fetch_word[7:4] == OP_NOP) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        instr  <= fetch_word[7:4];
                        portin <= fetch_word[3:0];
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    instr <= OP_NOP;
                    if (issue_wait == '0) begin
                        pc    <= pc + PW'(1);
                        state <= S_FETCH;
                    end else begin
                        cnt   <= issue_wait;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        pc    <= pc + PW'(1);
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    instr <= OP_NOP;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer.
// Inputs change and outputs are sampled on the falling edge.
// Expected values are worked out by hand from the cycle timeline.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] instr;
    logic [3:0] portin;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    instr_sequencer #(
        .DEPTH(16), .ALU_WAIT(2), .MEM_WAIT(2), .XFER_WAIT(1)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .abort(abort),
        .instr(instr), .portin(portin), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Each call crosses one rising edge and returns at the falling edge that follows it.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    // Pulse start; returns observing cycle N+1.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic exp_out(input string tag, input logic [3:0] ei, input logic [3:0] ep,
                           input logic [3:0] epc, input logic eb, input logic ed);
        chk({tag, ".instr"},  32'(instr),  32'(ei));
        chk({tag, ".portin"}, 32'(portin), 32'(ep));
        chk({tag, ".pc"},     32'(pc),     32'(epc));
        chk({tag, ".busy"},   32'(busy),   32'(eb));
        chk({tag, ".done"},   32'(done),   32'(ed));
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        exp_out("reset", 4'h9, 4'h0, 4'h0, 1'b0, 1'b0);

        // Empty store: HALT at pc 0
        pulse_start();
        exp_out("empty_n1", 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        exp_out("empty_n2", 4'h9, 4'h0, 4'h0, 1'b0, 1'b1);

        // Zero-wait opcodes, loaded while in DONE
        load(4'd0, 8'h65);
        load(4'd1, 8'h70);
        load(4'd2, 8'h90);
        exp_out("done_hold", 4'h9, 4'h0, 4'h0, 1'b0, 1'b1);
        pulse_start();
        exp_out("p1_n1", 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);
        step(); exp_out("p1_n2", 4'h6, 4'h5, 4'h0, 1'b1, 1'b0);
        step(); exp_out("p1_n3", 4'h9, 4'h5, 4'h1, 1'b1, 1'b0);
        step(); exp_out("p1_n4", 4'h7, 4'h0, 4'h1, 1'b1, 1'b0);
        step(); exp_out("p1_n5", 4'h9, 4'h0, 4'h2, 1'b1, 1'b0);
        step(); exp_out("p1_n6", 4'h9, 4'h0, 4'h2, 1'b0, 1'b1);

        // Memory read with two wait cycles, then an ALU op
        load(4'd0, 8'h43);
        load(4'd1, 8'h00);
        pulse_start();
        step(); exp_out("p2_n2", 4'h4, 4'h3, 4'h0, 1'b1, 1'b0);
        step(); exp_out("p2_w1", 4'h9, 4'h3, 4'h0, 1'b1, 1'b0);
        step(); exp_out("p2_w2", 4'h9, 4'h3, 4'h0, 1'b1, 1'b0);
        step(); exp_out("p2_f",  4'h9, 4'h3, 4'h1, 1'b1, 1'b0);
        step(); exp_out("p2_n6", 4'h0, 4'h0, 4'h1, 1'b1, 1'b0);
        step(); exp_out("p2_w3", 4'h9, 4'h0, 4'h1, 1'b1, 1'b0);
        step();
        step(); exp_out("p2_f2", 4'h9, 4'h0, 4'h2, 1'b1, 1'b0);
        step(); exp_out("p2_dn", 4'h9, 4'h0, 4'h2, 1'b0, 1'b1);

        // Full store of {0110,k}: pc wraps 15 -> 0
        for (int k = 0; k < 16; k++)
            load(4'(k), {4'h6, 4'(k)});
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            step();
            exp_out($sformatf("wrap_iss%0d", k), 4'h6, 4'(k), 4'(k), 1'b1, 1'b0);
            step();
        end
        exp_out("wrap_f0", 4'h9, 4'hF, 4'h0, 1'b1, 1'b0);
        step(); exp_out("wrap_iss0b", 4'h6, 4'h0, 4'h0, 1'b1, 1'b0);
        step();
        step(); exp_out("wrap_iss1b", 4'h6, 4'h1, 4'h1, 1'b1, 1'b0);
        pulse_abort();
        exp_out("abort_iss", 4'h9, 4'h1, 4'h1, 1'b0, 1'b0);

        // Abort during the wait of a memory write
        load(4'd2, 8'h52);
        pulse_start();
        step(); step(); step(); step();
        step(); exp_out("ab_iss2", 4'h5, 4'h2, 4'h2, 1'b1, 1'b0);
        step(); exp_out("ab_wait", 4'h9, 4'h2, 4'h2, 1'b1, 1'b0);
        pulse_abort();
        exp_out("ab_idle", 4'h9, 4'h2, 4'h2, 1'b0, 1'b0);
        step(); exp_out("ab_idle2", 4'h9, 4'h2, 4'h2, 1'b0, 1'b0);

        // load_en and start while busy are ignored
        pulse_start();
        step(); step();
        load_en = 1'b1; load_addr = 4'd5; load_data = 8'h90; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        exp_out("busy_iss1", 4'h6, 4'h1, 4'h1, 1'b1, 1'b0);
        step(); step(); exp_out("busy_iss2", 4'h5, 4'h2, 4'h2, 1'b1, 1'b0);
        step(); step(); step(); step(); exp_out("busy_iss3", 4'h6, 4'h3, 4'h3, 1'b1, 1'b0);
        step(); step(); step(); step(); exp_out("busy_iss5", 4'h6, 4'h5, 4'h5, 1'b1, 1'b0);
        pulse_abort();

        // Reset during WAIT clears outputs and the store
        pulse_start();
        step(); step(); step(); step();
        step(); exp_out("rst_iss2", 4'h5, 4'h2, 4'h2, 1'b1, 1'b0);
        step(); exp_out("rst_wait", 4'h9, 4'h2, 4'h2, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_out("rst_out", 4'h9, 4'h0, 4'h0, 1'b0, 1'b0);
        pulse_start();
        step(); exp_out("rst_store", 4'h9, 4'h0, 4'h0, 1'b0, 1'b1);

        // Same-cycle load and start: FETCH sees the new word
        load_en = 1'b1; load_addr = 4'd0; load_data = 8'h6A; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        exp_out("ls_n1", 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);
        step(); exp_out("ls_n2", 4'h6, 4'hA, 4'h0, 1'b1, 1'b0);
        step();
        step(); exp_out("ls_n4", 4'h9, 4'hA, 4'h1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
